dqsw_training_ctrl: RTL

DQSW_TRAINING_CTRL -- requirements
Module: dqsw_training_ctrl

---
 rtl/dqsw_training_pkg.sv | 35 +++
 rtl/dqsw_settle_timer.sv | 31 +++
 rtl/dqsw_training_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dqsw_training_pkg.sv
// rtl/dqsw_training_pkg.sv - shared state and sample-classification types for DQS-window training
package dqsw_training_pkg;

    // Width of the settle countdown; covers the full 1..255 settle range.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_SAMPLE = 3'd4,
        ST_STEP   = 3'd5,
        ST_PASS   = 3'd6,
        ST_FAIL   = 3'd7
    } dqsw_state_e;

    typedef enum logic [1:0] {
        SMP_AMBIG = 2'd0,
        SMP_EARLY = 2'd1,
        SMP_LATE  = 2'd2
    } dqsw_sample_e;

    // A flag pair is only meaningful when exactly one flag is set.
    function automatic dqsw_sample_e classify_sample(input logic early, input logic late);
        dqsw_sample_e s;
        case ({early, late})
            2'b10:   s = SMP_EARLY;
            2'b01:   s = SMP_LATE;
            default: s = SMP_AMBIG;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dqsw_settle_timer.sv
// rtl/dqsw_settle_timer.sv - loadable countdown that flags the last settle cycle
module dqsw_settle_timer
    import dqsw_training_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         count_i,
    input  logic [W-1:0] value_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // Load the settle length, then count down once per settle cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (count_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // Expires during the final counting cycle so the caller leaves on time.
    assign expire_o = count_i && (cnt_q == W'(1));

endmodule

// File: rtl/dqsw_training_ctrl.sv
// rtl/dqsw_training_ctrl.sv - sweeps the IOD delay line to find the late-to-early DQS edge
module dqsw_training_ctrl
    import dqsw_training_pkg::*;
#(
    parameter int MAX_TAPS      = 128,
    parameter int SETTLE_CYCLES = 8,
    parameter int TAP_W         = 8
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [TAP_W-1:0] TAP_RESULT,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE,
    input  logic             DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(MAX_TAPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);

    dqsw_state_e      state_q;
    logic [TAP_W-1:0] tap_q;
    logic [TAP_W-1:0] tap_d;
    logic [TAP_W-1:0] result_q;
    logic             seen_late_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             load_q;
    logic             move_q;
    logic             dir_q;
    logic             clr_q;
    logic             accept_d;
    logic             abort_d;
    logic             settle_done_d;
    dqsw_sample_e     sample_d;

    assign tap_d    = tap_q + TAP_W'(1);
    assign sample_d = classify_sample(EYE_MONITOR_EARLY, EYE_MONITOR_LATE);

    // A new sweep may only begin from a resting state; in FAIL that is after the restore pulse.
    assign accept_d = START && !busy_q &&
                      ((state_q == ST_IDLE) || (state_q == ST_PASS) || (state_q == ST_FAIL));

    // Out-of-range aborts any active sweep step; the FAIL restore cycle itself is exempt.
    assign abort_d  = DELAY_LINE_OUT_OF_RANGE && busy_q && (state_q != ST_FAIL);

    dqsw_settle_timer #(
        .W (CNT_W)
    ) u_settle_timer (
        .clk_i    (FAB_CLK),
        .rst_i    (RESET),
        .load_i   (state_q == ST_CLEAR),
        .count_i  (state_q == ST_SETTLE),
        .value_i  (SETTLE_VAL),
        .expire_o (settle_done_d)
    );

    // Sweep sequencer with every output held in a register.
    always_ff @(posedge FAB_CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            result_q    <= '0;
            seen_late_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            load_q      <= 1'b0;
            move_q      <= 1'b0;
            dir_q       <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            load_q <= 1'b0;
            move_q <= 1'b0;
            dir_q  <= 1'b0;
            clr_q  <= 1'b0;
            if (abort_d) begin
                state_q <= ST_FAIL;
                load_q  <= 1'b1;
            end else if (accept_d) begin
                state_q     <= ST_LOAD;
                tap_q       <= '0;
                result_q    <= '0;
                seen_late_q <= 1'b0;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                error_q     <= 1'b0;
                load_q      <= 1'b1;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        state_q <= ST_CLEAR;
                        clr_q   <= 1'b1;
                    end
                    ST_CLEAR: begin
                        state_q <= ST_SETTLE;
                    end
                    ST_SETTLE: begin
                        if (settle_done_d) begin
                            state_q <= ST_SAMPLE;
                        end
                    end
                    ST_SAMPLE: begin
                        if ((sample_d == SMP_EARLY) && seen_late_q) begin
                            state_q  <= ST_PASS;
                            result_q <= tap_q;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                        end else begin
                            if (sample_d == SMP_LATE) begin
                                seen_late_q <= 1'b1;
                            end
                            if (tap_q == LAST_TAP) begin
                                state_q <= ST_FAIL;
                                load_q  <= 1'b1;
                            end else begin
                                state_q <= ST_STEP;
                                move_q  <= 1'b1;
                                dir_q   <= 1'b1;
                            end
                        end
                    end
                    ST_STEP: begin
                        tap_q   <= tap_d;
                        state_q <= ST_CLEAR;
                        clr_q   <= 1'b1;
                    end
                    ST_FAIL: begin
                        if (busy_q) begin
                            busy_q   <= 1'b0;
                            error_q  <= 1'b1;
                            result_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign ERROR                   = error_q;
    assign TAP_RESULT              = result_q;
    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;

endmodule
